// File: rtl/io_bitbang_ctrl.sv
// Register-mapped direction/output/readback controller for the io_bitbang pin stage.
// Optional per-pin input debounce is enabled by defining IO_BITBANG_CTRL_DEBOUNCE_EN.
module io_bitbang_ctrl #(
  parameter int unsigned IO_NUM_OF       = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_req,
  input  logic                 in_wr,
  input  logic [2:0]           in_addr,
  input  logic [IO_NUM_OF-1:0] in_wdata,
  output logic                 out_ack,
  output logic [IO_NUM_OF-1:0] out_rdata,
  output logic [IO_NUM_OF-1:0] out_io_direction,
  output logic [IO_NUM_OF-1:0] out_io_outval,
  input  logic [IO_NUM_OF-1:0] in_io_inputval,
  output logic                 out_irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [2:0] A_DIR     = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_OUT_SET = 3'd6;
  localparam logic [2:0] A_OUT_CLR = 3'd7;

  logic [1:0]           state_q, state_d;
  logic                 commit_c;
  logic [IO_NUM_OF-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q, prev_q;
  logic [IO_NUM_OF-1:0] status_d, w1c_c, edge_c, rdata_d;
  logic [IO_NUM_OF-1:0] sync_r [SYNC_STAGES];
  logic [IO_NUM_OF-1:0] sync_q;
  logic [IO_NUM_OF-1:0] in_val;
  logic                 ack_q, irq_q;
  logic [IO_NUM_OF-1:0] rdata_q;

  // Bus FSM state register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Bus FSM next state; an access is accepted only on the IDLE->ACK transition
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: if (in_req) begin
        state_d  = ST_ACK;
        commit_c = 1'b1;
      end
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!in_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Readback synchronizer
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= in_io_inputval;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef IO_BITBANG_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0]     cnt_q [IO_NUM_OF];
  logic [IO_NUM_OF-1:0] db_q;

  // Per-pin debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      db_q <= '0;
      for (int unsigned i = 0; i < IO_NUM_OF; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IO_NUM_OF; i++) begin
        if (sync_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (32'(cnt_q[i]) + 32'd1 >= DEBOUNCE_CYCLES) begin
          db_q[i]  <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign in_val = db_q;
`else
  logic unused_debounce;
  assign unused_debounce = |DEBOUNCE_CYCLES;
  assign in_val          = sync_q;
`endif

  // Edge flags; a same-cycle edge beats a write-1-to-clear
  assign w1c_c    = (commit_c && in_wr && in_addr == A_STATUS) ? in_wdata : '0;
  assign edge_c   = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);
  assign status_d = (status_q & ~w1c_c) | edge_c;

  always_comb begin
    rdata_d = '0;
    if (commit_c && !in_wr) begin
      case (in_addr)
        A_DIR:     rdata_d = dir_q;
        A_OUT:     rdata_d = out_q;
        A_IN:      rdata_d = in_val;
        A_RISE_EN: rdata_d = rise_en_q;
        A_FALL_EN: rdata_d = fall_en_q;
        A_STATUS:  rdata_d = status_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  // Register file, edge history and registered bus outputs
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q   <= in_val;
      status_q <= status_d;
      irq_q    <= |status_d;
      ack_q    <= commit_c;
      rdata_q  <= rdata_d;
      if (commit_c && in_wr) begin
        case (in_addr)
          A_DIR:     dir_q     <= in_wdata;
          A_OUT:     out_q     <= in_wdata;
          A_RISE_EN: rise_en_q <= in_wdata;
          A_FALL_EN: fall_en_q <= in_wdata;
          A_OUT_SET: out_q     <= out_q | in_wdata;
          A_OUT_CLR: out_q     <= out_q & ~in_wdata;
          default:   ;
        endcase
      end
    end
  end

  assign out_ack          = ack_q;
  assign out_rdata        = rdata_q;
  assign out_io_direction = dir_q;
  assign out_io_outval    = out_q;
  assign out_irq          = irq_q;

endmodule

// File: tb/tb_io_bitbang_ctrl.sv
// Randomized self-checking bench for io_bitbang_ctrl against a register-level model.
// Debounce checks are compiled in when IO_BITBANG_CTRL_DEBOUNCE_EN is defined.
module tb_io_bitbang_ctrl;

  localparam int unsigned N = 10;
  localparam int unsigned S = 2;
  localparam int unsigned D = 16;
`ifdef IO_BITBANG_CTRL_DEBOUNCE_EN
  localparam int unsigned SETTLE = S + D + 4;
`else
  localparam int unsigned SETTLE = S + 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         wr;
  logic [2:0]   addr;
  logic [N-1:0] wdata;
  logic         ack;
  logic [N-1:0] rdata;
  logic [N-1:0] io_dir;
  logic [N-1:0] io_out;
  logic [N-1:0] pins;
  logic         irq;

  io_bitbang_ctrl #(.IO_NUM_OF(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_req           (req),
    .in_wr            (wr),
    .in_addr          (addr),
    .in_wdata         (wdata),
    .out_ack          (ack),
    .out_rdata        (rdata),
    .out_io_direction (io_dir),
    .out_io_outval    (io_out),
    .in_io_inputval   (pins),
    .out_irq          (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural register contents and settled pin levels
  logic [N-1:0] dir_m, out_m, rise_m, fall_m, status_m, pins_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    dir_m = '0; out_m = '0; rise_m = '0; fall_m = '0; status_m = '0;
  endtask

  task automatic mdl_write(input logic [2:0] a, input logic [N-1:0] w);
    case (a)
      3'd0: dir_m = w;
      3'd1: out_m = w;
      3'd3: rise_m = w;
      3'd4: fall_m = w;
      3'd5: status_m = status_m & ~w;
      3'd6: out_m = out_m | w;
      3'd7: out_m = out_m & ~w;
      default: ;
    endcase
  endtask

  function automatic logic [N-1:0] mdl_read(input logic [2:0] a);
    case (a)
      3'd0: return dir_m;
      3'd1: return out_m;
      3'd2: return pins_m;
      3'd3: return rise_m;
      3'd4: return fall_m;
      3'd5: return status_m;
      default: return '0;
    endcase
  endfunction

  // One four-phase access; called and returns at a negedge with the FSM idle
  task automatic bus(input logic w, input logic [2:0] a, input logic [N-1:0] d,
                     output logic [N-1:0] r);
    bit got = 0;
    r = '0;
    req = 1'b1; wr = w; addr = a; wdata = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        r   = rdata;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("dir_at_ack", 32'(io_dir), 32'(dir_m));
    chk("out_at_ack", 32'(io_out), 32'(out_m));
    req = 1'b0; wr = 1'b0; wdata = '0;
    @(negedge clk);
    chk("ack_width", 32'(ack), 32'd0);
    chk("rdata_idle", 32'(rdata), 32'd0);
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [N-1:0] d);
    logic [N-1:0] r;
    mdl_write(a, d);
    bus(1'b1, a, d, r);
  endtask

  task automatic reg_rd(input logic [2:0] a);
    logic [N-1:0] r;
    logic [N-1:0] e;
    e = mdl_read(a);
    bus(1'b0, a, '0, r);
    chk($sformatf("rd_a%0d", a), 32'(r), 32'(e));
  endtask

  // Drive a new pin vector and let it settle; edges follow from old/new levels
  task automatic set_pins(input logic [N-1:0] nv);
    logic [N-1:0] ov;
    ov   = pins_m;
    pins = nv;
    repeat (SETTLE) @(negedge clk);
    status_m = status_m | (nv & ~ov & rise_m) | (~nv & ov & fall_m);
    pins_m   = nv;
    chk("irq_settled", 32'(irq), 32'(|status_m));
  endtask

  initial begin
    logic [N-1:0] r;
    int acks;
    bit got;

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; pins = '0;
    pins_m = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_dir", 32'(io_dir), 32'd0);
    chk("rst_out", 32'(io_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    for (int a = 0; a < 8; a++) reg_rd(3'(a));

    reg_wr(3'd0, 10'h3FF);
    reg_wr(3'd1, 10'h155);
    reg_wr(3'd6, 10'h002);
    chk("out_set", 32'(io_out), 32'h157);
    reg_wr(3'd7, 10'h101);
    chk("out_clr", 32'(io_out), 32'h056);
    reg_rd(3'd1);
    reg_wr(3'd2, 10'h3FF);
    reg_rd(3'd2);

`ifndef IO_BITBANG_CTRL_DEBOUNCE_EN
    // Rise on bit0: flag and irq appear exactly S+1 edges after the pin moves
    reg_wr(3'd3, 10'h001);
    pins = 10'h001;
    for (int k = 1; k <= int'(S) + 1; k++) begin
      @(negedge clk);
      chk($sformatf("irq_lat%0d", k), 32'(irq), 32'(k == int'(S) + 1));
    end
    status_m = 10'h001;
    pins_m   = 10'h001;
    reg_rd(3'd5);
    set_pins(10'h000);
    reg_rd(3'd5);

    // W1C committed on the same edge as a new rise: the flag survives
    pins = 10'h001;
    repeat (S) @(negedge clk);
    bus(1'b1, 3'd5, 10'h001, r);
    pins_m = 10'h001;
    reg_rd(3'd5);
    reg_wr(3'd5, 10'h001);
    chk("irq_cleared", 32'(irq), 32'd0);
    reg_rd(3'd5);
`endif

    // Long request: one ack only
    mdl_write(3'd0, 10'h2AA);
    req = 1'b1; wr = 1'b1; addr = 3'd0; wdata = 10'h2AA;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack) acks++;
    end
    req = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack_count", 32'(acks), 32'd1);
    chk("dir_long", 32'(io_dir), 32'h2AA);

    // Reset while the FSM waits for req to drop
    mdl_write(3'd1, 10'h0F0);
    req = 1'b1; wr = 1'b1; addr = 3'd1; wdata = 10'h0F0;
    got = 0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    chk("ack_before_rst", 32'(got), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; wr = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_dir", 32'(io_dir), 32'd0);
    chk("rst_mid_out", 32'(io_out), 32'd0);
    rst_n = 1'b1;
    repeat (SETTLE) @(negedge clk);
    reg_wr(3'd0, 10'h3C3);
    reg_rd(3'd0);
    reg_rd(3'd5);

    // Random mix of register accesses and pin activity
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 2))
        0: reg_wr(3'($urandom_range(0, 7)), N'($urandom));
        1: reg_rd(3'($urandom_range(0, 7)));
        default: set_pins(N'($urandom));
      endcase
    end
    for (int a = 0; a < 8; a++) reg_rd(3'(a));

`ifdef IO_BITBANG_CTRL_DEBOUNCE_EN
    set_pins(pins_m & ~10'h008);
    reg_wr(3'd3, 10'h008);
    reg_wr(3'd5, 10'h3FF);
    // Short glitch is swallowed
    pins = pins_m | 10'h008;
    repeat (10) @(negedge clk);
    pins = pins_m;
    repeat (SETTLE) @(negedge clk);
    reg_rd(3'd2);
    reg_rd(3'd5);
    // Long pulse is accepted
    pins = pins_m | 10'h008;
    repeat (S + D + 1) @(negedge clk);
    bus(1'b0, 3'd2, '0, r);
    chk("db_in3", 32'(r[3]), 32'd1);
    status_m = status_m | 10'h008;
    pins     = pins_m;
    repeat (SETTLE) @(negedge clk);
    status_m = status_m | (fall_m & 10'h008);
    reg_rd(3'd5);
    chk("db_irq", 32'(irq), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
